foo_status_writer: RTL and testbench
====================================

Name: foo_status_writer

Overview:
- Owns the packed per-slot 2-bit status word that downstream inactive-slot decoders consume.
- Accepts single-slot status updates over a valid/ready handshake.
- Auto-retires DRAIN slots to INACTIVE after a fixed countdown.
- Publishes both the registered current word and the combinational next-cycle word, so consumers can decode either view.

Parameters:
- NUM_SLOTS, 7, number of 2-bit status fields packed from bit 0 upward; legal range 1..16.
- DRAIN_CYCLES, 4, cycles a slot remains in DRAIN before auto-clearing to INACTIVE; must be >= 1.
- CNT_W, $clog2(DRAIN_CYCLES+1), width of each per-slot drain counter.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_upd_valid  input  1  update request valid.
- o_upd_ready  output  1  update can be accepted this cycle.
- i_upd_slot  input  4  target slot index.
- i_upd_state  input  2  new state: 00 INACTIVE, 01 REQUESTED, 10 ACTIVE, 11 DRAIN.
- i_clear_all  input  1  force every slot to INACTIVE and cancel all drain counters.
- o_foo_current  output  32  registered packed status word; slot s occupies bits [2s+1:2s].
- o_foo_next  output  32  combinational value o_foo_current takes at the next edge.
- o_active_count  output  5  registered count of slots whose state is not 00.
- o_bad_slot  output  1  sticky flag: a handshake completed with i_upd_slot >= NUM_SLOTS.

Behaviour:
- Reset (i_rst_n low at an edge):
  - All slots 00, all counters 0.
  - o_foo_current = 0, o_active_count = 0, o_bad_slot = 0.
  - Reset overrides i_clear_all and any update.
- Unused bits [31:2*NUM_SLOTS] of both words are always 0.
- o_upd_ready = !i_clear_all && !(i_upd_slot < NUM_SLOTS && state[i_upd_slot] == 11).
  - A slot in DRAIN cannot be overwritten.
  - Ready may depend combinationally on i_upd_slot; ready does not depend on i_upd_valid.
- Accept = i_upd_valid && o_upd_ready.
  - Accepted update with in-range slot: slot takes i_upd_state at the edge, visible on o_foo_current the next cycle (1-cycle latency).
  - Accepted update with out-of-range slot: no state change; o_bad_slot sets and holds until reset.
- Writing 11: slot counter loads DRAIN_CYCLES.
  - Counter decrements each cycle while the slot is 11.
  - When the counter is 1, the next edge sets the slot to 00 and the counter to 0.
  - Net effect: the slot reads 11 on o_foo_current for exactly DRAIN_CYCLES cycles.
- Writing 00, 01, 10: counter for that slot forced to 0.
- Simultaneous events:
  - An update to slot A and drain expiry on slot B (A != B) both take effect in the same edge.
  - The same slot cannot see both, because ready is low while it is draining.
- i_clear_all high at an edge (reset high):
  - All slots 00, all counters 0.
  - Concurrent update is not accepted (ready low).
  - o_bad_slot is unaffected.
- o_foo_next:
  - Reflects reset, clear, accepted update and drain expiry for the coming edge.
  - With no event it equals o_foo_current.
- o_active_count is registered from o_foo_next, so it always matches o_foo_current in the same cycle.
- Reset asserted mid-drain: counters cleared, no auto-expiry after reset release.

Test Plan:
- Reset then write slot 2 = 10 -> next cycle o_foo_current = 32'h0000_0020, o_active_count = 1, o_foo_next = 32'h20 in the accept cycle.
- Write slot 0 = 11, DRAIN_CYCLES = 4 -> o_foo_current[1:0] = 11 for exactly 4 cycles then 00. o_upd_ready is low for slot 0 throughout, and high for slot 1.
- Slot 3 draining, write slot 5 = 01 in the expiry cycle -> next word has slot 3 = 00 and slot 5 = 01 (32'h0000_0400), count 1.
- Slots 0..6 all 10 (word 32'h0000_2AAA), pulse i_clear_all with i_upd_valid high for slot 1 = 01 -> o_upd_ready = 0, next word 0, count 0.
- Handshake with i_upd_slot = 9 -> word unchanged, o_bad_slot = 1 and stays set through i_clear_all; cleared only by i_rst_n low.
- Start drain on slot 4, assert i_rst_n low for 1 cycle mid-countdown, then keep slot 4 idle -> word stays 0, no spurious transition after release.

Source files
------------

// File: rtl/foo_status_writer.sv
// foo_status_writer: packed per-slot 2-bit status word with handshaked
// single-slot updates and timed DRAIN -> INACTIVE auto-retirement.
//
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_upd_valid      update request valid
//   o_upd_ready      update can be accepted this cycle
//   i_upd_slot       target slot index
//   i_upd_state      new state (00 INACTIVE, 01 REQ, 10 ACTIVE, 11 DRAIN)
//   i_clear_all      force all slots INACTIVE, cancel drain counters
//   o_foo_current    registered packed word, slot s at [2s+1:2s]
//   o_foo_next       value o_foo_current takes at the next edge
//   o_active_count   registered count of non-INACTIVE slots
//   o_bad_slot       sticky: handshake completed with slot >= NUM_SLOTS
module foo_status_writer #(
  parameter int NUM_SLOTS    = 7,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = $clog2(DRAIN_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_upd_valid,
  output logic        o_upd_ready,
  input  logic [3:0]  i_upd_slot,
  input  logic [1:0]  i_upd_state,
  input  logic        i_clear_all,
  output logic [31:0] o_foo_current,
  output logic [31:0] o_foo_next,
  output logic [4:0]  o_active_count,
  output logic        o_bad_slot
);

  localparam logic [1:0]       ST_DRAIN = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       st_q  [NUM_SLOTS];
  logic [1:0]       st_d  [NUM_SLOTS];
  logic [CNT_W-1:0] cnt_q [NUM_SLOTS];
  logic [CNT_W-1:0] cnt_d [NUM_SLOTS];

  logic [4:0]  count_q;
  logic [4:0]  count_d;
  logic        bad_q;
  logic        bad_d;
  logic [31:0] word_q;
  logic [31:0] word_d;

  logic in_range;
  logic tgt_drain;
  logic accept;

  assign in_range = {1'b0, i_upd_slot} < 5'(NUM_SLOTS);

  // Ready only looks at the addressed slot; out-of-range
  // slots are never draining so they stay ready.
  always_comb begin
    tgt_drain = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (i_upd_slot == 4'(s) && st_q[s] == ST_DRAIN)
        tgt_drain = 1'b1;
    end
  end

  assign o_upd_ready = !i_clear_all && !tgt_drain;
  assign accept      = i_upd_valid && o_upd_ready;

  // Per-slot next state. Priority, lowest to highest:
  // drain countdown, accepted update, clear/reset.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      st_d[s]  = st_q[s];
      cnt_d[s] = cnt_q[s];
      if (st_q[s] == ST_DRAIN) begin
        if (cnt_q[s] <= CNT_ONE) begin
          st_d[s]  = 2'b00;
          cnt_d[s] = '0;
        end else begin
          cnt_d[s] = cnt_q[s] - CNT_ONE;
        end
      end
      if (accept && in_range && i_upd_slot == 4'(s)) begin
        st_d[s]  = i_upd_state;
        cnt_d[s] = (i_upd_state == ST_DRAIN) ? CNT_LOAD : '0;
      end
      if (!i_rst_n || i_clear_all) begin
        st_d[s]  = 2'b00;
        cnt_d[s] = '0;
      end
    end
  end

  always_comb begin
    word_d  = '0;
    count_d = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      word_d[2*s +: 2] = st_d[s];
      count_d          = count_d + 5'(|st_d[s]);
    end
  end

  assign bad_d = i_rst_n && (bad_q || (accept && !in_range));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        st_q[s]  <= 2'b00;
        cnt_q[s] <= '0;
      end
      word_q  <= '0;
      count_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        st_q[s]  <= st_d[s];
        cnt_q[s] <= cnt_d[s];
      end
      word_q  <= word_d;
      count_q <= count_d;
      bad_q   <= bad_d;
    end
  end

  assign o_foo_current  = word_q;
  assign o_foo_next     = word_d;
  assign o_active_count = count_q;
  assign o_bad_slot     = bad_q;

endmodule

// File: tb/tb_foo_status_writer.sv
// tb_foo_status_writer: directed vector table plus a drain-length
// sequence for foo_status_writer (NUM_SLOTS=7, DRAIN_CYCLES=4).
module tb_foo_status_writer;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  upd_slot;
  logic [1:0]  upd_state;
  logic        clear_all;
  logic [31:0] foo_current;
  logic [31:0] foo_next;
  logic [4:0]  active_count;
  logic        bad_slot;

  int n_vec;
  int n_err;

  foo_status_writer #(
    .NUM_SLOTS   (7),
    .DRAIN_CYCLES(4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_upd_valid   (upd_valid),
    .o_upd_ready   (upd_ready),
    .i_upd_slot    (upd_slot),
    .i_upd_state   (upd_state),
    .i_clear_all   (clear_all),
    .o_foo_current (foo_current),
    .o_foo_next    (foo_next),
    .o_active_count(active_count),
    .o_bad_slot    (bad_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [3:0]  slot;
    logic [1:0]  st;
    logic        clr;
    logic        rdy;
    logic [31:0] nxt;
    logic [31:0] cur;
    logic [4:0]  cnt;
    logic        bad;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic r, input logic v, input logic [3:0] sl,
    input logic [1:0] st, input logic c, input logic rdy,
    input logic [31:0] nxt, input logic [31:0] cur,
    input logic [4:0] cnt, input logic bad);
    vec_t e;
    e.rst_n = r; e.valid = v; e.slot = sl; e.st = st; e.clr = c;
    e.rdy = rdy; e.nxt = nxt; e.cur = cur; e.cnt = cnt; e.bad = bad;
    tbl.push_back(e);
  endtask

  task automatic drive(
    input logic r, input logic v, input logic [3:0] sl,
    input logic [1:0] st, input logic c);
    @(negedge clk);
    rst_n = r; upd_valid = v; upd_slot = sl;
    upd_state = st; clear_all = c;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int drain_len;
    bit done;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; upd_valid = 1'b0; upd_slot = '0;
    upd_state = '0; clear_all = 1'b0;
    repeat (2) @(posedge clk);

    //  rst v slot st clr | rdy nxt cur cnt bad
    add(0, 0, 0, 0, 0, 1, 32'h0,    32'h0,    0, 0);
    add(1, 1, 2, 2, 0, 1, 32'h20,   32'h0,    0, 0);
    add(1, 0, 0, 0, 0, 1, 32'h20,   32'h20,   1, 0);
    add(1, 1, 0, 3, 0, 1, 32'h23,   32'h20,   1, 0);
    add(1, 1, 0, 1, 0, 0, 32'h23,   32'h23,   2, 0);
    add(1, 1, 1, 0, 0, 1, 32'h23,   32'h23,   2, 0);
    add(1, 0, 0, 0, 0, 0, 32'h23,   32'h23,   2, 0);
    add(1, 0, 0, 0, 0, 0, 32'h20,   32'h23,   2, 0);
    add(1, 0, 0, 0, 0, 1, 32'h20,   32'h20,   1, 0);
    add(1, 0, 0, 0, 1, 0, 32'h0,    32'h20,   1, 0);
    add(1, 1, 3, 3, 0, 1, 32'hC0,   32'h0,    0, 0);
    add(1, 0, 3, 0, 0, 0, 32'hC0,   32'hC0,   1, 0);
    add(1, 0, 3, 0, 0, 0, 32'hC0,   32'hC0,   1, 0);
    add(1, 0, 3, 0, 0, 0, 32'hC0,   32'hC0,   1, 0);
    add(1, 1, 5, 1, 0, 1, 32'h400,  32'hC0,   1, 0);
    add(1, 0, 0, 0, 0, 1, 32'h400,  32'h400,  1, 0);
    add(1, 1, 0, 2, 0, 1, 32'h402,  32'h400,  1, 0);
    add(1, 1, 1, 2, 0, 1, 32'h40A,  32'h402,  2, 0);
    add(1, 1, 2, 2, 0, 1, 32'h42A,  32'h40A,  3, 0);
    add(1, 1, 3, 2, 0, 1, 32'h4AA,  32'h42A,  4, 0);
    add(1, 1, 4, 2, 0, 1, 32'h6AA,  32'h4AA,  5, 0);
    add(1, 1, 5, 2, 0, 1, 32'hAAA,  32'h6AA,  6, 0);
    add(1, 1, 6, 2, 0, 1, 32'h2AAA, 32'hAAA,  6, 0);
    add(1, 1, 1, 1, 1, 0, 32'h0,    32'h2AAA, 7, 0);
    add(1, 0, 0, 0, 0, 1, 32'h0,    32'h0,    0, 0);
    add(1, 1, 9, 2, 0, 1, 32'h0,    32'h0,    0, 0);
    add(1, 0, 0, 0, 0, 1, 32'h0,    32'h0,    0, 1);
    add(1, 0, 0, 0, 1, 0, 32'h0,    32'h0,    0, 1);
    add(1, 1, 7, 3, 0, 1, 32'h0,    32'h0,    0, 1);
    add(0, 0, 0, 0, 0, 1, 32'h0,    32'h0,    0, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0,    32'h0,    0, 0);
    add(1, 1, 4, 3, 0, 1, 32'h300,  32'h0,    0, 0);
    add(1, 0, 0, 0, 0, 1, 32'h300,  32'h300,  1, 0);
    add(0, 1, 0, 2, 0, 1, 32'h0,    32'h300,  1, 0);
    add(1, 0, 4, 0, 0, 1, 32'h0,    32'h0,    0, 0);
    add(1, 0, 4, 0, 0, 1, 32'h0,    32'h0,    0, 0);
    add(1, 0, 4, 0, 0, 1, 32'h0,    32'h0,    0, 0);
    add(1, 0, 4, 0, 0, 1, 32'h0,    32'h0,    0, 0);
    add(1, 0, 4, 0, 0, 1, 32'h0,    32'h0,    0, 0);
    add(1, 0, 4, 0, 0, 1, 32'h0,    32'h0,    0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].valid, tbl[i].slot,
            tbl[i].st, tbl[i].clr);
      n_vec++;
      chk($sformatf("v%0d ready", i), 32'(upd_ready),    32'(tbl[i].rdy));
      chk($sformatf("v%0d next", i),  foo_next,          tbl[i].nxt);
      chk($sformatf("v%0d cur", i),   foo_current,       tbl[i].cur);
      chk($sformatf("v%0d count", i), 32'(active_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d bad", i),   32'(bad_slot),     32'(tbl[i].bad));
    end

    // Drain slot 6 and measure how long it reads 11, with a
    // slot-1 write landing mid-countdown.
    drive(1, 1, 6, 3, 0);
    n_vec++;
    chk("seq start ready", 32'(upd_ready), 32'h1);
    drain_len = 0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c == 2) drive(1, 1, 1, 2, 0);
      else        drive(1, 0, 6, 0, 0);
      if (foo_current[13:12] == 2'b11) begin
        drain_len++;
        if (c != 2) begin
          n_vec++;
          chk($sformatf("seq c%0d ready", c), 32'(upd_ready), 32'h0);
        end
      end else if (drain_len > 0) begin
        done = 1;
      end
    end
    n_vec++;
    chk("seq drain length", 32'(drain_len), 32'd4);
    chk("seq end word", foo_current, 32'h8);
    chk("seq end count", 32'(active_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
